// File: rtl/gps_pkg.sv
// Shared constants and the nibble packing helper for the GPS sample packer.
// Nibble layout is {I1,I0,Q1,Q0}; the overflow counter saturates at all-ones.
package gps_pkg;
  localparam int GPS_NIBBLE_W = 4;
  localparam int NIB_I1       = 3;
  localparam int NIB_I0       = 2;
  localparam int NIB_Q1       = 1;
  localparam int NIB_Q0       = 0;
  localparam int OVF_COUNT_W  = 8;
  localparam int ST_CNT_W     = GPS_NIBBLE_W;

  localparam logic [OVF_COUNT_W-1:0] OVF_COUNT_MAX = '1;

  typedef logic [GPS_NIBBLE_W-1:0] nibble_t;

  function automatic nibble_t pack_nibble(input logic i1, input logic i0,
                                          input logic q1, input logic q0);
    nibble_t n;
    n         = '0;
    n[NIB_I1] = i1;
    n[NIB_I0] = i0;
    n[NIB_Q1] = q1;
    n[NIB_Q0] = q0;
    return n;
  endfunction
endpackage

// File: rtl/gps_word_fifo.sv
// Synchronous first-word-fall-through word FIFO; head is visible the cycle after its push.
// A push into a full FIFO is refused unless a pop frees a slot that same cycle; level port with GPS_SAMPLE_PACKER_LEVEL_EN.
module gps_word_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3,
  parameter int WIDTH      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
`ifdef GPS_SAMPLE_PACKER_LEVEL_EN
  ,
  output logic [FIFO_AW:0] level_o
`endif
);

  logic [WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               push_ok;
  logic               pop_ok;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == (FIFO_AW+1)'(FIFO_DEPTH));
  assign pop_ok     = pop_i & ~empty_o;
  assign push_ok    = push_i & (~full_o | pop_ok);
  // Gate the head so the output reads zero whenever nothing is stored.
  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

`ifdef GPS_SAMPLE_PACKER_LEVEL_EN
  assign level_o = cnt_q;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + FIFO_AW'(push_ok);
    rd_ptr_d = rd_ptr_q + FIFO_AW'(pop_ok);
    cnt_d    = cnt_q + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/gps_sample_packer.sv
// Packs 2-bit I/Q samples into words (first sample in the top nibble) and queues them in an FWFT FIFO.
// Word valid one cycle after its final strobe; full FIFO drops words and counts them; GPS_SAMPLE_PACKER_LEVEL_EN adds FIFO_LEVEL.
module gps_sample_packer
  import gps_pkg::*;
#(
  parameter int SAMPLES_PER_WORD = 4,
  parameter int FIFO_DEPTH       = 8,
  parameter int FIFO_AW          = 3
) (
  input  logic                                     MCU_CLK,
  input  logic                                     RESET,
  input  logic                                     SAMPLE_STB,
  input  logic                                     GPS_I0,
  input  logic                                     GPS_I1,
  input  logic                                     GPS_Q0,
  input  logic                                     GPS_Q1,
  input  logic                                     SELF_TEST,
  output logic [GPS_NIBBLE_W*SAMPLES_PER_WORD-1:0] WORD_DATA,
  output logic                                     WORD_VALID,
  input  logic                                     WORD_READY,
  output logic                                     OVERFLOW,
  output logic [OVF_COUNT_W-1:0]                   OVF_COUNT
`ifdef GPS_SAMPLE_PACKER_LEVEL_EN
  ,
  output logic [FIFO_AW:0]                         FIFO_LEVEL
`endif
);

  localparam int WORD_W = GPS_NIBBLE_W * SAMPLES_PER_WORD;
  localparam int IDX_W  = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_WORD - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   mode_q, mode_d;
  logic [ST_CNT_W-1:0]    st_cnt_q, st_cnt_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic                   ovf_q, ovf_d;
  logic [OVF_COUNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic              mode_eff;
  nibble_t           nib;
  logic [WORD_W-1:0] word_base;
  logic [WORD_W-1:0] word_ins;
  logic              word_done;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              drop;

  // The self-test selection is latched by the word's first strobe and held until it completes.
  assign mode_eff  = (state_q == ST_IDLE) ? SELF_TEST : mode_q;
  assign nib       = mode_eff ? nibble_t'(st_cnt_q) : pack_nibble(GPS_I1, GPS_I0, GPS_Q1, GPS_Q0);
  assign word_base = (state_q == ST_IDLE) ? '0 : word_q;
  assign word_ins  = word_base | (WORD_W'(nib) << (GPS_NIBBLE_W * int'(LAST_IDX - idx_q)));
  assign word_done = SAMPLE_STB & (idx_q == LAST_IDX);

  assign WORD_VALID = ~fifo_empty;
  assign pop        = WORD_VALID & WORD_READY;
  assign drop       = word_done & fifo_full & ~pop;
  assign OVERFLOW   = ovf_q;
  assign OVF_COUNT  = ovf_cnt_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    st_cnt_d  = st_cnt_q;
    word_d    = word_q;
    ovf_d     = ovf_q | drop;
    ovf_cnt_d = ovf_cnt_q;
    if (drop && ovf_cnt_q != OVF_COUNT_MAX) ovf_cnt_d = ovf_cnt_q + 1'b1;
    if (SAMPLE_STB) begin
      mode_d = mode_eff;
      word_d = word_ins;
      if (mode_eff) st_cnt_d = st_cnt_q + 1'b1;
      if (word_done) begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_FILL;
      end
    end
  end

  always_ff @(posedge MCU_CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      mode_q    <= 1'b0;
      st_cnt_q  <= '0;
      word_q    <= '0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      st_cnt_q  <= st_cnt_d;
      word_q    <= word_d;
      ovf_q     <= ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  gps_word_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW),
    .WIDTH      (WORD_W)
  ) u_fifo (
    .clk_i      (MCU_CLK),
    .rst_i      (RESET),
    .push_i     (word_done),
    .push_dat_i (word_ins),
    .pop_i      (pop),
    .head_dat_o (WORD_DATA),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
`ifdef GPS_SAMPLE_PACKER_LEVEL_EN
    ,
    .level_o    (FIFO_LEVEL)
`endif
  );

endmodule

// File: tb/tb_gps_sample_packer.sv
// Randomized bench for gps_sample_packer against a queue-based reference model.
module tb_gps_sample_packer;

  logic        MCU_CLK = 1'b0;
  logic        RESET, SAMPLE_STB, GPS_I0, GPS_I1, GPS_Q0, GPS_Q1, SELF_TEST, WORD_READY;
  logic [15:0] WORD_DATA;
  logic        WORD_VALID, OVERFLOW;
  logic [7:0]  OVF_COUNT;
`ifdef GPS_SAMPLE_PACKER_LEVEL_EN
  logic [3:0]  FIFO_LEVEL;
`endif

  always #5 MCU_CLK = ~MCU_CLK;

  gps_sample_packer dut (
    .MCU_CLK(MCU_CLK), .RESET(RESET), .SAMPLE_STB(SAMPLE_STB),
    .GPS_I0(GPS_I0), .GPS_I1(GPS_I1), .GPS_Q0(GPS_Q0), .GPS_Q1(GPS_Q1),
    .SELF_TEST(SELF_TEST), .WORD_DATA(WORD_DATA), .WORD_VALID(WORD_VALID),
    .WORD_READY(WORD_READY), .OVERFLOW(OVERFLOW), .OVF_COUNT(OVF_COUNT)
`ifdef GPS_SAMPLE_PACKER_LEVEL_EN
    , .FIFO_LEVEL(FIFO_LEVEL)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: list of nibbles of the word being built, queue of stored words.
  bit [15:0] mq[$];
  bit [3:0]  nibs[$];
  bit        m_mode;
  int        m_st;
  bit        m_ovf;
  int        m_cnt;

  task automatic model_clear();
    mq.delete(); nibs.delete();
    m_mode = 0; m_st = 0; m_ovf = 0; m_cnt = 0;
  endtask

  task automatic step(input bit stb, input bit [3:0] iq, input bit st, input bit rdy);
    bit [15:0] w;
    SAMPLE_STB = stb;
    {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0} = iq;
    SELF_TEST  = st;
    WORD_READY = rdy;
    @(posedge MCU_CLK);
    if (rdy && mq.size() != 0) void'(mq.pop_front());
    if (stb) begin
      if (nibs.size() == 0) m_mode = st;
      if (m_mode) begin
        nibs.push_back(4'(m_st));
        m_st = (m_st + 1) % 16;
      end else begin
        nibs.push_back(iq);
      end
      if (nibs.size() == 4) begin
        w = {nibs[0], nibs[1], nibs[2], nibs[3]};
        nibs.delete();
        if (mq.size() < 8) mq.push_back(w);
        else begin
          m_ovf = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    SAMPLE_STB = 1'($urandom);
    SELF_TEST  = 1'($urandom);
    WORD_READY = 1'($urandom);
    @(posedge MCU_CLK);
    model_clear();
    #1;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (WORD_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", WORD_VALID); end
    n_cmp++; if (WORD_DATA !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0000", WORD_DATA); end
    n_cmp++; if (OVERFLOW !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", OVERFLOW); end
    n_cmp++; if (OVF_COUNT !== 8'd0) begin n_bad++; $display("FAIL reset_ovfcnt: got %0d want 0", OVF_COUNT); end
`ifdef GPS_SAMPLE_PACKER_LEVEL_EN
    n_cmp++; if (FIFO_LEVEL !== 4'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", FIFO_LEVEL); end
`endif
  endtask

  task automatic test_basic();
    bit [3:0] vals[4];
    int vcyc;
    vals = '{4'hA, 4'h5, 4'hF, 4'h0};
    vcyc = 0;
    for (int k = 0; k < 7; k++) begin
      step(k < 4, (k < 4) ? vals[k] : 4'($urandom), 1'b0, 1'b1);
      if (WORD_VALID) vcyc++;
      if (k == 3) begin
        n_cmp++; if (WORD_VALID !== 1'b1 || WORD_DATA !== 16'hA5F0) begin
          n_bad++; $display("FAIL basic_word: got v=%b %h want v=1 a5f0", WORD_VALID, WORD_DATA); end
      end
      n_cmp++; if (WORD_VALID !== (mq.size() != 0)) begin
        n_bad++; $display("FAIL basic_valid: got %b want %b", WORD_VALID, mq.size() != 0); end
    end
    n_cmp++; if (vcyc != 1) begin n_bad++; $display("FAIL basic_valid_cycles: got %0d want 1", vcyc); end
  endtask

  task automatic test_self_test();
    bit [15:0] got[$];
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(k < 8, 4'($urandom), 1'b1, 1'b1);
      if (WORD_VALID) got.push_back(WORD_DATA);
      n_cmp++; if (WORD_VALID !== (mq.size() != 0) || (mq.size() != 0 && WORD_DATA !== mq[0])) begin
        n_bad++; $display("FAIL st_cycle%0d: got v=%b %h want v=%b", k, WORD_VALID, WORD_DATA, mq.size() != 0); end
    end
    n_cmp++; if (got.size() != 2) begin n_bad++; $display("FAIL st_count: got %0d want 2", got.size()); end
    else begin
      n_cmp++; if (got[0] !== 16'h0123 || got[1] !== 16'h4567) begin
        n_bad++; $display("FAIL st_words: got %h %h want 0123 4567", got[0], got[1]); end
    end
    n_cmp++; if (OVF_COUNT !== 8'd0) begin n_bad++; $display("FAIL st_drops: got %0d want 0", OVF_COUNT); end
  endtask

  task automatic test_overflow();
    int pops;
    do_reset();
    for (int k = 0; k < 36; k++) begin
      step(1'b1, 4'($urandom), 1'b0, 1'b0);
      n_cmp++; if (WORD_VALID !== (mq.size() != 0) || (mq.size() != 0 && WORD_DATA !== mq[0])) begin
        n_bad++; $display("FAIL ovf_fill%0d: got v=%b %h", k, WORD_VALID, WORD_DATA); end
    end
    n_cmp++; if (OVERFLOW !== 1'b1 || OVF_COUNT !== 8'd1) begin
      n_bad++; $display("FAIL ovf_flag: got %b/%0d want 1/1", OVERFLOW, OVF_COUNT); end
    pops = 0;
    for (int k = 0; k < 10; k++) begin
      if (WORD_VALID) pops++;
      step(1'b0, 4'($urandom), 1'($urandom), 1'b1);
      n_cmp++; if (WORD_VALID !== (mq.size() != 0) || (mq.size() != 0 && WORD_DATA !== mq[0])) begin
        n_bad++; $display("FAIL ovf_drain%0d: got v=%b %h", k, WORD_VALID, WORD_DATA); end
`ifdef GPS_SAMPLE_PACKER_LEVEL_EN
      n_cmp++; if (FIFO_LEVEL !== 4'(mq.size())) begin
        n_bad++; $display("FAIL ovf_level%0d: got %0d want %0d", k, FIFO_LEVEL, mq.size()); end
`endif
    end
    n_cmp++; if (pops != 8) begin n_bad++; $display("FAIL ovf_drain_count: got %0d want 8", pops); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int k = 0; k < 36; k++) step(1'b1, 4'($urandom), 1'b0, k == 35);
    n_cmp++; if (OVERFLOW !== 1'b0 || OVF_COUNT !== 8'd0) begin
      n_bad++; $display("FAIL fullpop_drop: got %b/%0d want 0/0", OVERFLOW, OVF_COUNT); end
    n_cmp++; if (WORD_VALID !== 1'b1 || WORD_DATA !== mq[0]) begin
      n_bad++; $display("FAIL fullpop_head: got %h want %h", WORD_DATA, mq[0]); end
`ifdef GPS_SAMPLE_PACKER_LEVEL_EN
    n_cmp++; if (FIFO_LEVEL !== 4'd8) begin n_bad++; $display("FAIL fullpop_level: got %0d want 8", FIFO_LEVEL); end
`endif
  endtask

  task automatic test_mode_toggle();
    bit [3:0]  iq[4];
    bit [15:0] got[$];
    bit [15:0] w0;
    do_reset();
    for (int k = 0; k < 4; k++) iq[k] = 4'($urandom);
    w0 = {iq[0], iq[1], iq[2], iq[3]};
    for (int k = 0; k < 10; k++) begin
      step(k < 8, (k < 4) ? iq[k] : 4'($urandom), k >= 2, 1'b1);
      if (WORD_VALID) got.push_back(WORD_DATA);
    end
    n_cmp++; if (got.size() != 2) begin n_bad++; $display("FAIL toggle_count: got %0d want 2", got.size()); end
    else begin
      n_cmp++; if (got[0] !== w0) begin n_bad++; $display("FAIL toggle_w0: got %h want %h", got[0], w0); end
      n_cmp++; if (got[1] !== 16'h0123) begin n_bad++; $display("FAIL toggle_w1: got %h want 0123", got[1]); end
    end
  endtask

  task automatic test_reset_mid();
    bit [15:0] got[$];
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1, 4'($urandom), 1'b0, 1'b0);
    do_reset();
    n_cmp++; if (WORD_VALID !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", WORD_VALID); end
    for (int k = 0; k < 7; k++) begin
      step(k < 4, 4'h1, 1'b0, 1'b1);
      if (WORD_VALID) got.push_back(WORD_DATA);
    end
    n_cmp++; if (got.size() != 1 || got[0] !== 16'h1111) begin
      n_bad++; $display("FAIL rstmid_words: got %0d words first %h want 1 word 1111",
                        got.size(), (got.size() != 0) ? got[0] : 16'h0); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 4 * 308; k++) step(1'b1, 4'($urandom), 1'($urandom), 1'b0);
    n_cmp++; if (OVF_COUNT !== 8'd255 || OVERFLOW !== 1'b1) begin
      n_bad++; $display("FAIL saturate: got %0d/%b want 255/1", OVF_COUNT, OVERFLOW); end
    n_cmp++; if (OVF_COUNT !== 8'(m_cnt)) begin
      n_bad++; $display("FAIL saturate_model: got %0d want %0d", OVF_COUNT, m_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
      n_cmp++; if (WORD_VALID !== (mq.size() != 0) || (mq.size() != 0 && WORD_DATA !== mq[0])) begin
        n_bad++; $display("FAIL rand_word%0d: got v=%b %h want v=%b %h", k, WORD_VALID, WORD_DATA,
                          mq.size() != 0, (mq.size() != 0) ? mq[0] : 16'h0); end
      n_cmp++; if (OVERFLOW !== m_ovf || OVF_COUNT !== 8'(m_cnt)) begin
        n_bad++; $display("FAIL rand_ovf%0d: got %b/%0d want %b/%0d", k, OVERFLOW, OVF_COUNT, m_ovf, m_cnt); end
`ifdef GPS_SAMPLE_PACKER_LEVEL_EN
      n_cmp++; if (FIFO_LEVEL !== 4'(mq.size())) begin
        n_bad++; $display("FAIL rand_level%0d: got %0d want %0d", k, FIFO_LEVEL, mq.size()); end
`endif
    end
  endtask

  initial begin
    RESET = 1'b1; SAMPLE_STB = 1'b0; SELF_TEST = 1'b0; WORD_READY = 1'b0;
    GPS_I0 = 1'b0; GPS_I1 = 1'b0; GPS_Q0 = 1'b0; GPS_Q1 = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_self_test();
    test_overflow();
    test_full_pop();
    test_mode_toggle();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
